button_conditioner_bank: RTL and testbench
==========================================

Name: button_conditioner_bank

Overview:
- Multi-channel replacement for the single-channel button conditioner.
- Per channel: synchronises a raw pad input, optionally inverts it, debounces it, and emits a clean level plus one-cycle press/release strobes.
- Sits between board pads (io_button, rst_n, io_dip) and user logic or debug endpoint action inputs; one instance serves a whole button group.

Parameters:
- CHANNELS, 5, number of independent input channels (≥1).
- STAGES, 4, synchroniser flip-flop depth per channel (≥2).
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a new level (≥1); counter width = $clog2(DEBOUNCE_CYCLES+1).
- INVERT_MASK, {CHANNELS{1'b0}}, bit i = 1 inverts in[i] before the synchroniser (active-low pads).
- HOLD_CYCLES, 50_000_000, cycles of held level before first repeat strobe (used only with HOLD_REPEAT_EN).
- REPEAT_CYCLES, 10_000_000, cycles between subsequent repeat strobes (used only with HOLD_REPEAT_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in  input  CHANNELS  raw asynchronous pad inputs.
- level  output  CHANNELS  debounced level, post-inversion.
- pressed  output  CHANNELS  one-cycle strobe on accepted 0→1 of level[i].
- released  output  CHANNELS  one-cycle strobe on accepted 1→0 of level[i].
- any_pressed  output  1  OR of pressed, same cycle.
- repeat_out  output  CHANNELS  hold/auto-repeat strobes (tied 0 without HOLD_REPEAT_EN).

Behaviour:
- One clock, one reset. Reset is synchronous and active-high. Ports are clk and rst.
- Reset: all synchroniser stages, level, pressed, released, repeat_out and every counter clear to 0. Reset values apply regardless of the in/INVERT_MASK state. After reset, an inverted idle-high pad reads 0 with no strobe.
- Per channel: x = in[i] ^ INVERT_MASK[i], then pass x through STAGES flops. sync[i] is the last stage.
- Debounce counter cnt[i], evaluated each edge:
  - If sync[i] == level[i]: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level[i] ← sync[i], cnt ← 0, and pressed/released[i] ← 1 per direction.
  - Else: cnt ← cnt+1.
- Latency: edge 0 is the first edge that samples the new in value. level[i] and the strobe are visible after edge STAGES+DEBOUNCE_CYCLES-1.
- DEBOUNCE_CYCLES = 1: level follows sync with one register stage.
- pressed, released and repeat_out are registered. Each is high for exactly one cycle and 0 in all other cycles. pressed and released are never both high on the same channel.
- Glitch rejection: a mismatch shorter than DEBOUNCE_CYCLES consecutive cycles resets cnt and is never reported.
- Channels are fully independent. Simultaneous transitions on several channels strobe in the same cycle.
- Reset mid-debounce discards the pending count. No strobe is emitted.
- The counter saturates structurally, because it clears at its terminal value. No wrap-around is possible.

Optional Feature:
- Macro: HOLD_REPEAT_EN.
- Defined:
  - Per channel, hold counter h[i] runs while level[i] = 1 and clears when level[i] = 0 or on rst.
  - repeat_out[i] pulses one cycle when h reaches HOLD_CYCLES after the press strobe, then every REPEAT_CYCLES thereafter while held.
  - A release stops repeats immediately. There is no repeat in the release cycle.
- Undefined: no hold counters are synthesised, repeat_out = 0 constantly, and HOLD_CYCLES/REPEAT_CYCLES are ignored.

Test Plan (CHANNELS=2, STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3):
1. rst high 3 cycles with in=2'b00, then release → all outputs 0 and stay 0 for 20 cycles.
2. in[0] 0→1 at edge 0, held → level[0]=1 and pressed[0]=1 after edge 5. pressed[0]=0 after edge 6. in[0] 1→0 → released[0] single pulse 5 edges later.
3. in[0] high for 3 samples, low for 1, repeated 5 times → level[0], pressed[0] and released[0] never assert.
4. INVERT_MASK=2'b01, in[0]=1 idle after reset → level[0]=0 and no strobe. in[0]→0 → level[0]=1 and pressed[0] after edge 5.
5. Both in bits rise on the same edge → pressed=2'b11 and any_pressed=1 in one cycle. Reset asserted at edge 3 of a new press → no strobe, level unchanged at 0.
6. HOLD_REPEAT_EN defined, in[1] held high → repeat_out[1] pulses 10, 13 and 16 cycles after pressed[1]. Releasing in[1] → no further pulses. Without the macro → repeat_out stays 0.

Source files
------------

// File: rtl/button_conditioner_bank.sv
// Multi-channel pad conditioner: per-channel synchroniser, optional inversion, debounce, press/release strobes.
// Optional hold/auto-repeat strobes are built only when HOLD_REPEAT_EN is defined.
module button_conditioner_bank #(
    parameter int unsigned          CHANNELS        = 5,
    parameter int unsigned          STAGES          = 4,
    parameter int unsigned          DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [CHANNELS-1:0]  INVERT_MASK     = '0,
    parameter int unsigned          HOLD_CYCLES     = 50_000_000,
    parameter int unsigned          REPEAT_CYCLES   = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic                any_pressed,
    output logic [CHANNELS-1:0] repeat_out
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_q [STAGES];
    logic [CHANNELS-1:0] sync;
    logic [CHANNELS-1:0] level_nxt;
    logic [CHANNELS-1:0] accept;
    logic [CW-1:0]       cnt     [CHANNELS];
    logic [CW-1:0]       cnt_nxt [CHANNELS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in ^ INVERT_MASK;
            for (int unsigned s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync = sync_q[STAGES-1];

    // The counter clears at its terminal value, so it can never wrap.
    always_comb begin
        level_nxt = level;
        accept    = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            cnt_nxt[ch] = cnt[ch] + CW'(1);
            if (sync[ch] == level[ch]) begin
                cnt_nxt[ch] = '0;
            end else if (cnt[ch] == CNT_LAST) begin
                cnt_nxt[ch]   = '0;
                accept[ch]    = 1'b1;
                level_nxt[ch] = sync[ch];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level    <= '0;
            pressed  <= '0;
            released <= '0;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) cnt[ch] <= '0;
        end else begin
            level    <= level_nxt;
            pressed  <= accept & level_nxt;
            released <= accept & ~level_nxt;
            cnt      <= cnt_nxt;
        end
    end

    assign any_pressed = |pressed;

`ifdef HOLD_REPEAT_EN
    localparam int unsigned    HMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned    HW        = $clog2(HMAX + 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]  REP_LAST  = HW'(REPEAT_CYCLES - 1);

    logic [HW-1:0]       hold_cnt [CHANNELS];
    logic [HW-1:0]       hold_nxt [CHANNELS];
    logic [CHANNELS-1:0] rep_phase;
    logic [CHANNELS-1:0] rep_phase_nxt;
    logic [CHANNELS-1:0] rep_fire;

    // Gating on level_nxt suppresses a repeat in the same cycle a release is accepted.
    always_comb begin
        rep_fire      = '0;
        rep_phase_nxt = rep_phase;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            hold_nxt[ch] = hold_cnt[ch] + HW'(1);
            if (!level_nxt[ch] || !level[ch]) begin
                hold_nxt[ch]      = '0;
                rep_phase_nxt[ch] = 1'b0;
            end else if (hold_cnt[ch] == (rep_phase[ch] ? REP_LAST : HOLD_LAST)) begin
                hold_nxt[ch]      = '0;
                rep_phase_nxt[ch] = 1'b1;
                rep_fire[ch]      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_phase  <= '0;
            repeat_out <= '0;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) hold_cnt[ch] <= '0;
        end else begin
            rep_phase  <= rep_phase_nxt;
            repeat_out <= rep_fire;
            hold_cnt   <= hold_nxt;
        end
    end
`else
    assign repeat_out = '0;
`endif

endmodule

// File: tb/tb_button_conditioner_bank.sv
// Directed self-checking bench for button_conditioner_bank (2 channels, 2 stages, debounce 4, hold 10, repeat 3).
module tb_button_conditioner_bank;

    logic       clk;
    logic       rst;
    logic [1:0] in_a, in_b;
    logic [1:0] level_a, pressed_a, released_a, repeat_a;
    logic [1:0] level_b, pressed_b, released_b, repeat_b;
    logic       any_a, any_b;

    int vectors     = 0;
    int miscompares = 0;
    bit hold_en;

    button_conditioner_bank #(
        .CHANNELS(2), .STAGES(2), .DEBOUNCE_CYCLES(4), .INVERT_MASK(2'b00),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .in(in_a), .level(level_a), .pressed(pressed_a),
        .released(released_a), .any_pressed(any_a), .repeat_out(repeat_a)
    );

    button_conditioner_bank #(
        .CHANNELS(2), .STAGES(2), .DEBOUNCE_CYCLES(4), .INVERT_MASK(2'b01),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
    ) dut_inv (
        .clk(clk), .rst(rst), .in(in_b), .level(level_b), .pressed(pressed_b),
        .released(released_b), .any_pressed(any_b), .repeat_out(repeat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_a = 2'b00;
        in_b = 2'b00;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step();
            vectors++;
            if ({level_a, pressed_a, released_a, any_a, repeat_a} !== 9'b0) begin
                miscompares++;
                $display("FAIL reset_idle cyc%0d: got lvl=%b prs=%b rel=%b any=%b rep=%b expected all 0",
                         k, level_a, pressed_a, released_a, any_a, repeat_a);
            end
        end
    endtask

    task automatic test_press_release();
        logic exp_lvl, exp_prs, exp_rel;
        in_a = 2'b01;
        for (int k = 0; k <= 6; k++) begin
            step();
            exp_lvl = (k >= 5);
            exp_prs = (k == 5);
            vectors++;
            if ({level_a[0], pressed_a[0], any_a, released_a[0]} !== {exp_lvl, exp_prs, exp_prs, 1'b0}) begin
                miscompares++;
                $display("FAIL press edge%0d: got lvl=%b prs=%b any=%b rel=%b expected lvl=%b prs=%b any=%b rel=0",
                         k, level_a[0], pressed_a[0], any_a, released_a[0], exp_lvl, exp_prs, exp_prs);
            end
        end
        in_a = 2'b00;
        for (int k = 0; k <= 6; k++) begin
            step();
            exp_lvl = (k < 5);
            exp_rel = (k == 5);
            vectors++;
            if ({level_a[0], released_a[0], pressed_a[0]} !== {exp_lvl, exp_rel, 1'b0}) begin
                miscompares++;
                $display("FAIL release edge%0d: got lvl=%b rel=%b prs=%b expected lvl=%b rel=%b prs=0",
                         k, level_a[0], released_a[0], pressed_a[0], exp_lvl, exp_rel);
            end
        end
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                in_a = (k < 3) ? 2'b01 : 2'b00;
                step();
                vectors++;
                if ({level_a[0], pressed_a[0], released_a[0]} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL glitch r%0d k%0d: got lvl=%b prs=%b rel=%b expected 0 0 0",
                             r, k, level_a[0], pressed_a[0], released_a[0]);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if ({level_a[0], pressed_a[0], released_a[0]} !== 3'b000) begin
                miscompares++;
                $display("FAIL glitch_tail k%0d: got lvl=%b prs=%b rel=%b expected 0 0 0",
                         k, level_a[0], pressed_a[0], released_a[0]);
            end
        end
    endtask

    task automatic test_invert();
        logic exp_lvl, exp_prs;
        in_b = 2'b01;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step();
            vectors++;
            if ({level_b[0], pressed_b[0], released_b[0]} !== 3'b000) begin
                miscompares++;
                $display("FAIL invert_idle cyc%0d: got lvl=%b prs=%b rel=%b expected 0 0 0",
                         k, level_b[0], pressed_b[0], released_b[0]);
            end
        end
        in_b = 2'b00;
        for (int k = 0; k <= 6; k++) begin
            step();
            exp_lvl = (k >= 5);
            exp_prs = (k == 5);
            vectors++;
            if ({level_b[0], pressed_b[0]} !== {exp_lvl, exp_prs}) begin
                miscompares++;
                $display("FAIL invert_press edge%0d: got lvl=%b prs=%b expected lvl=%b prs=%b",
                         k, level_b[0], pressed_b[0], exp_lvl, exp_prs);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_prs, exp_lvl;
        in_a = 2'b11;
        for (int k = 0; k <= 6; k++) begin
            step();
            exp_prs = (k == 5) ? 2'b11 : 2'b00;
            exp_lvl = (k >= 5) ? 2'b11 : 2'b00;
            vectors++;
            if ({pressed_a, any_a, level_a} !== {exp_prs, (k == 5), exp_lvl}) begin
                miscompares++;
                $display("FAIL simul edge%0d: got prs=%b any=%b lvl=%b expected prs=%b any=%b lvl=%b",
                         k, pressed_a, any_a, level_a, exp_prs, (k == 5), exp_lvl);
            end
        end
        in_a = 2'b00;
        repeat (8) step();
        vectors++;
        if (level_a !== 2'b00) begin
            miscompares++;
            $display("FAIL simul_release: got lvl=%b expected 00", level_a);
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [1:0] exp_prs, exp_lvl;
        in_a = 2'b11;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({level_a, pressed_a} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst edge3: got lvl=%b prs=%b expected 00 00", level_a, pressed_a);
        end
        // The held input restarts from scratch on the edge after reset.
        for (int k = 4; k <= 10; k++) begin
            step();
            exp_prs = (k == 9) ? 2'b11 : 2'b00;
            exp_lvl = (k >= 9) ? 2'b11 : 2'b00;
            vectors++;
            if ({level_a, pressed_a} !== {exp_lvl, exp_prs}) begin
                miscompares++;
                $display("FAIL midrst edge%0d: got lvl=%b prs=%b expected lvl=%b prs=%b",
                         k, level_a, pressed_a, exp_lvl, exp_prs);
            end
        end
        in_a = 2'b00;
        repeat (8) step();
    endtask

    task automatic test_repeat();
        logic [1:0] exp_rep;
        logic       exp_rel;
        in_a = 2'b00;
        do_reset();
        repeat (2) step();
        in_a = 2'b10;
        repeat (6) step();
        vectors++;
        if (pressed_a !== 2'b10) begin
            miscompares++;
            $display("FAIL repeat_press: got prs=%b expected 10", pressed_a);
        end
        for (int j = 1; j <= 16; j++) begin
            step();
            exp_rep = {hold_en && (j == 10 || j == 13 || j == 16), 1'b0};
            vectors++;
            if (repeat_a !== exp_rep) begin
                miscompares++;
                $display("FAIL repeat_hold P+%0d: got rep=%b expected %b", j, repeat_a, exp_rep);
            end
        end
        in_a = 2'b00;
        for (int j = 17; j <= 30; j++) begin
            step();
            exp_rep = {hold_en && (j == 19), 1'b0};
            exp_rel = (j == 22);
            vectors++;
            if ({repeat_a, released_a[1]} !== {exp_rep, exp_rel}) begin
                miscompares++;
                $display("FAIL repeat_release P+%0d: got rep=%b rel=%b expected rep=%b rel=%b",
                         j, repeat_a, released_a[1], exp_rep, exp_rel);
            end
        end
    endtask

    initial begin
`ifdef HOLD_REPEAT_EN
        hold_en = 1'b1;
`else
        hold_en = 1'b0;
`endif
        rst  = 1'b1;
        in_a = 2'b00;
        in_b = 2'b00;
        test_reset();
        test_press_release();
        test_glitch();
        test_invert();
        test_simultaneous();
        test_reset_mid_debounce();
        test_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
